// File: rtl/io_input_handshake.sv
// io_input_handshake
// Device side of the CPU Input instruction handshake: synchronises and
// debounces the active-low Enter key, synchronises the switch bank, and on a
// fresh key press during an outstanding request captures the switches,
// extends them to 32 bits and pulses ack for one cycle.
module io_input_handshake #(
    parameter int DATA_W          = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SIGN_EXT        = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req,
    input  logic              enter_n,
    input  logic [DATA_W-1:0] sw,
    output logic [31:0]       data,
    output logic              ack,
    output logic              waiting
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_WAIT_RELEASE
    } state_t;

    logic              r_key_s1;
    logic              r_key_s2;
    logic [DATA_W-1:0] r_sw_s1;
    logic [DATA_W-1:0] r_sw_s2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_deb;
    logic              r_press;
    state_t            r_state;
    logic [31:0]       r_data;
    logic              r_ack;
    logic              r_waiting;
    logic [31:0]       w_ext;

    // Two-flop synchronisers; key presets to released (high), switches clear
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= enter_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Debounce: the debounced level follows the synced key only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; r_press strobes on a
    // released->pressed flip. Flipping on CNT_LAST is the cycle the counter
    // would reach DEBOUNCE_CYCLES.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_deb   <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_key_s2 != r_deb) begin
                if (r_cnt == CNT_LAST) begin
                    r_deb   <= r_key_s2;
                    r_cnt   <= '0;
                    r_press <= ~r_key_s2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Zero- or sign-extension of the synchronised switch value to 32 bits
    always_comb begin
        w_ext = ((SIGN_EXT != 0) && r_sw_s2[DATA_W-1]) ? '1 : '0;
        w_ext[DATA_W-1:0] = r_sw_s2;
    end

    // Handshake FSM with registered data/ack/waiting outputs
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_ack     <= 1'b0;
            r_waiting <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state   <= S_WAIT_PRESS;
                        r_waiting <= 1'b1;
                    end
                end
                S_WAIT_PRESS: begin
                    if (!req) begin
                        r_state   <= S_IDLE;
                        r_waiting <= 1'b0;
                    end else if (r_press) begin
                        r_state   <= S_WAIT_RELEASE;
                        r_waiting <= 1'b0;
                        r_data    <= w_ext;
                        r_ack     <= 1'b1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (r_deb) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_waiting <= 1'b0;
                end
            endcase
        end
    end

    assign data    = r_data;
    assign ack     = r_ack;
    assign waiting = r_waiting;

endmodule

// File: tb/tb_io_input_handshake.sv
// Bench for io_input_handshake: two instances (zero- and sign-extending)
// share one stimulus; a behavioural model predicts captures into a queue and
// a negedge monitor pops and compares them when the DUT acks.
module tb_io_input_handshake;

    localparam int DW  = 10;
    localparam int DEB = 4;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          enter_n = 1'b0;
    logic [DW-1:0] sw = '0;
    logic [31:0]   data0, data1;
    logic          ack0, ack1, waiting0, waiting1;

    io_input_handshake #(.DATA_W(DW), .DEBOUNCE_CYCLES(DEB), .SIGN_EXT(0)) u_dut0 (
        .CLK(CLK), .reset(reset), .req(req), .enter_n(enter_n), .sw(sw),
        .data(data0), .ack(ack0), .waiting(waiting0)
    );

    io_input_handshake #(.DATA_W(DW), .DEBOUNCE_CYCLES(DEB), .SIGN_EXT(1)) u_dut1 (
        .CLK(CLK), .reset(reset), .req(req), .enter_n(enter_n), .sw(sw),
        .data(data1), .ack(ack1), .waiting(waiting1)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_acks  = 0;
    int last_ack_cyc = -1;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] zext(input logic [DW-1:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] sext(input logic [DW-1:0] v);
        logic [31:0] r;
        r = 32'(v);
        if (v >= (1 << (DW - 1))) r = r | (32'hFFFF_FFFF << DW);
        return r;
    endfunction

    // Reference model: inputs seen at each edge are delayed two edges in a
    // history queue; the debounced level follows after DEB consecutive
    // disagreeing samples; a press becomes visible to the handshake one edge later.
    logic [DW-1:0] swq[$] = '{'0, '0};
    logic          kq[$]  = '{1'b1, 1'b1};
    logic          m_deb = 1'b1;
    int            m_run = 0;
    logic          m_press = 1'b0;
    int            m_phase = 0;   // 0 idle, 1 waiting for press, 2 waiting for release
    logic [31:0]   m_d0 = '0, m_d1 = '0;
    logic          m_ack = 1'b0;

    always @(posedge CLK) begin
        cyc++;
        if (!reset) begin
            swq = '{'0, '0};
            kq  = '{1'b1, 1'b1};
            m_deb = 1'b1; m_run = 0; m_press = 1'b0; m_phase = 0;
            m_d0 = '0; m_d1 = '0; m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (m_phase == 0) begin
                if (req) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!req) m_phase = 0;
                else if (m_press) begin
                    m_phase = 2;
                    m_d0 = zext(swq[0]);
                    m_d1 = sext(swq[0]);
                    m_ack = 1'b1;
                    exp_q.push_back('{m_d0, m_d1});
                end
            end else begin
                if (m_deb) m_phase = 0;
            end
            m_press = 1'b0;
            if (kq[0] != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb = ~m_deb;
                    m_run = 0;
                    m_press = (m_deb == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            void'(kq.pop_front());
            kq.push_back(enter_n);
            void'(swq.pop_front());
            swq.push_back(sw);
        end
    end

    // Monitor: pop and compare when the DUT acks; track held outputs each cycle
    always @(negedge CLK) begin
        exp_t e;
        if (ack0) begin
            n_acks++;
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack0), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_data_zext", data0, e.d0);
                chk("ack_data_sext", data1, e.d1);
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_ack", 32'(ack0), 32'd1);
            void'(exp_q.pop_front());
        end
        chk("ack_sext_inst", 32'(ack1), 32'(m_ack));
        chk("held_data_zext", data0, m_d0);
        chk("held_data_sext", data1, m_d1);
        chk("waiting0", 32'(waiting0), 32'(m_phase == 1));
        chk("waiting1", 32'(waiting1), 32'(m_phase == 1));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int a0;
        int fall;
        logic [31:0] dsave;

        // 1: reset with key pressed and all switches high
        reset = 1'b0; enter_n = 1'b0; sw = 10'h3FF; req = 1'b0;
        tick(3);
        chk("rst_data", data0, 32'd0);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_waiting", 32'(waiting0), 32'd0);
        reset = 1'b1;
        a0 = n_acks;
        tick(8);
        chk("post_rst_no_ack", 32'(n_acks - a0), 32'd0);
        enter_n = 1'b1;
        tick(10);

        // 2: capture latency and extension
        sw = 10'h155; req = 1'b1;
        tick(3);
        a0 = n_acks; enter_n = 1'b0; fall = cyc;
        tick(12);
        chk("cap1_count", 32'(n_acks - a0), 32'd1);
        chk("cap1_latency", 32'(last_ack_cyc - fall), 32'd7);
        chk("cap1_data", data0, 32'h0000_0155);
        enter_n = 1'b1;
        tick(10);
        sw = 10'h200;
        tick(3);
        enter_n = 1'b0;
        tick(12);
        chk("cap2_zext", data0, 32'h0000_0200);
        chk("cap2_sext", data1, 32'hFFFF_FE00);
        enter_n = 1'b1;
        tick(10);

        // 3: bounce shorter than the debounce window
        sw = 10'h0A5; a0 = n_acks;
        for (int i = 0; i < 10; i++) begin
            enter_n = ~enter_n;
            tick(2);
        end
        chk("bounce_no_ack", 32'(n_acks - a0), 32'd0);
        enter_n = 1'b0; fall = cyc;
        tick(15);
        chk("bounce_one_ack", 32'(n_acks - a0), 32'd1);
        chk("bounce_latency", 32'(last_ack_cyc - fall), 32'd7);
        enter_n = 1'b1;
        tick(10);

        // 4: key held before request is never accepted
        req = 1'b0;
        tick(2);
        enter_n = 1'b0;
        tick(10);
        a0 = n_acks; req = 1'b1;
        tick(50);
        chk("held_key_no_ack", 32'(n_acks - a0), 32'd0);
        enter_n = 1'b1;
        tick(10);
        enter_n = 1'b0;
        tick(12);
        chk("repress_one_ack", 32'(n_acks - a0), 32'd1);
        enter_n = 1'b1;
        tick(10);

        // 5: req falls on the press-edge cycle
        sw = 10'h3C3; dsave = data0; a0 = n_acks;
        enter_n = 1'b0;
        tick(6);
        req = 1'b0;
        tick(10);
        chk("req_drop_no_ack", 32'(n_acks - a0), 32'd0);
        chk("req_drop_data", data0, dsave);
        chk("req_drop_idle", 32'(waiting0), 32'd0);
        enter_n = 1'b1;
        tick(10);

        // 6: reset during WAIT_RELEASE
        req = 1'b1;
        tick(3);
        enter_n = 1'b0;
        tick(10);
        reset = 1'b0;
        tick(1);
        reset = 1'b1; enter_n = 1'b1; req = 1'b0; a0 = n_acks;
        tick(15);
        chk("rst_mid_no_ack", 32'(n_acks - a0), 32'd0);
        chk("rst_mid_data", data0, 32'd0);
        chk("rst_mid_waiting", 32'(waiting0), 32'd0);

        // 7: randomized traffic against the model
        for (int s = 0; s < 300; s++) begin
            req = ($urandom_range(0, 3) != 0);
            sw = DW'($urandom);
            enter_n = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 49) == 0) reset = 1'b0;
            tick(1);
            reset = 1'b1;
            tick($urandom_range(0, 11));
        end

        req = 1'b0; enter_n = 1'b1;
        tick(20);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
